// File: rtl/ehter_rx_fcs_check.sv
// Purpose: receive 2-bit RMII-style symbols, strip preamble/SFD/FCS, check the CRC-32, count frames.
// Latency: a payload byte appears 1 cycle after the symbol that completes the byte 4 positions later.
// Backpressure: none; every valid symbol is accepted and the byte output cannot be stalled.
//
// Ports:
//   clk, reset                     core clock, asynchronous active-high reset
//   s_rx_data/valid/last           input symbol stream; the LS bit pair of each byte comes first
//   m_data/valid/first/last        payload byte stream, one-cycle strobes
//   m_fcs_ok                       verdict, only meaningful on the m_last byte
//   good_count, bad_count          saturating frame statistics
module ehter_rx_fcs_check #(
    parameter int COUNTER_BITS = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_rx_last,
    input  logic [1:0]              s_rx_data,
    input  logic                    s_rx_valid,
    output logic                    m_first,
    output logic                    m_last,
    output logic [7:0]              m_data,
    output logic                    m_valid,
    output logic                    m_fcs_ok,
    output logic [COUNTER_BITS-1:0] good_count,
    output logic [COUNTER_BITS-1:0] bad_count
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  phase;
    logic [5:0]  acc;            // first three symbols of the byte being assembled
    logic [31:0] crc;
    logic [7:0]  fifo [0:3];     // fifo[0] is always the oldest byte
    logic [2:0]  fifo_cnt;
    logic        first_pend;     // no byte of the current DATA frame has been emitted yet

    logic        byte_done;
    logic        eof;
    logic        fifo_full;
    logic [7:0]  new_byte;
    logic [31:0] crc_nxt;

    // control decisions from the FSM
    logic        push;
    logic        emit;
    logic        emit_last;
    logic        emit_ok;
    logic        inc_good;
    logic        inc_bad;
    logic        crc_init;

    // Reflected CRC-32, one byte, no final inversion: the register is compared
    // against the fixed residue after the FCS bytes have been folded in.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign byte_done = s_rx_valid && (phase == 2'd3);
    assign eof       = s_rx_valid && s_rx_last;
    assign fifo_full = (fifo_cnt == 3'd4);
    assign new_byte  = {s_rx_data, acc};
    assign crc_nxt   = crc_byte(crc, new_byte);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        emit      = 1'b0;
        emit_last = 1'b0;
        emit_ok   = 1'b0;
        inc_good  = 1'b0;
        inc_bad   = 1'b0;
        crc_init  = 1'b0;

        case (state)
            HUNT: begin
                if (byte_done) begin
                    if (new_byte == 8'hD5) begin
                        state_nxt = DATA;
                        crc_init  = 1'b1;
                    end else if (new_byte != 8'h55) begin
                        state_nxt = DROP;
                    end
                end
            end
            DATA: begin
                if (byte_done) begin
                    push = 1'b1;
                    emit = fifo_full;
                end
                if (eof) begin
                    if (byte_done) begin
                        // A full FIFO before this byte means at least 5 complete bytes.
                        emit_last = fifo_full;
                        emit_ok   = fifo_full && (crc_nxt == CRC_RESIDUE);
                        inc_good  = emit_ok;
                        inc_bad   = !emit_ok;
                    end else begin
                        // Partial byte is dropped. With exactly 4 complete bytes the FIFO
                        // is full but nothing has been emitted, so the frame is too short
                        // and must stay silent; only close a frame that has already started.
                        emit      = fifo_full && !first_pend;
                        emit_last = fifo_full && !first_pend;
                        inc_bad   = 1'b1;
                    end
                end
            end
            default: begin
                // DROP: wait for the end of the frame
            end
        endcase

        if (eof) begin
            state_nxt = HUNT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase      <= 2'd0;
            acc        <= 6'd0;
            crc        <= CRC_INIT;
            fifo_cnt   <= 3'd0;
            first_pend <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                fifo[i] <= 8'd0;
            end
            m_valid    <= 1'b0;
            m_first    <= 1'b0;
            m_last     <= 1'b0;
            m_data     <= 8'd0;
            m_fcs_ok   <= 1'b0;
            good_count <= '0;
            bad_count  <= '0;
        end else begin
            m_valid  <= emit;
            m_first  <= emit && first_pend;
            m_last   <= emit_last;
            m_data   <= emit ? fifo[0] : 8'd0;
            m_fcs_ok <= emit_last && emit_ok;

            if (s_rx_valid) begin
                phase <= eof ? 2'd0 : phase + 2'd1;
                case (phase)
                    2'd0:    acc[1:0] <= s_rx_data;
                    2'd1:    acc[3:2] <= s_rx_data;
                    2'd2:    acc[5:4] <= s_rx_data;
                    default: ;
                endcase
            end

            if (crc_init) begin
                crc <= CRC_INIT;
            end else if (push) begin
                crc <= crc_nxt;
            end

            if (crc_init) begin
                first_pend <= 1'b1;
            end else if (emit) begin
                first_pend <= 1'b0;
            end

            if (eof) begin
                fifo_cnt <= 3'd0;
            end else if (push) begin
                if (fifo_full) begin
                    fifo[0] <= fifo[1];
                    fifo[1] <= fifo[2];
                    fifo[2] <= fifo[3];
                    fifo[3] <= new_byte;
                end else begin
                    fifo[fifo_cnt[1:0]] <= new_byte;
                    fifo_cnt            <= fifo_cnt + 3'd1;
                end
            end

            if (inc_good && (good_count != '1)) begin
                good_count <= good_count + COUNTER_BITS'(1);
            end
            if (inc_bad && (bad_count != '1)) begin
                bad_count <= bad_count + COUNTER_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_ehter_rx_fcs_check.sv
// Bench for ehter_rx_fcs_check: table of frame scenarios plus hand-written reset sequences.
module tb_ehter_rx_fcs_check;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_rx_last;
    logic [1:0]  s_rx_data;
    logic        s_rx_valid;
    logic        m_first;
    logic        m_last;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_fcs_ok;
    logic [15:0] good_count;
    logic [15:0] bad_count;

    always #5 clk = ~clk;

    ehter_rx_fcs_check #(.COUNTER_BITS(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_rx_last  (s_rx_last),
        .s_rx_data  (s_rx_data),
        .s_rx_valid (s_rx_valid),
        .m_first    (m_first),
        .m_last     (m_last),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_fcs_ok   (m_fcs_ok),
        .good_count (good_count),
        .bad_count  (bad_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- output monitor ----------------
    typedef struct packed {
        logic [7:0]  d;
        logic        f;
        logic        l;
        logic        ok;
        logic [31:0] cyc;
    } out_t;

    out_t outq[$];
    int   cyc_cnt    = 0;
    int   idle_dirty = 0;

    always @(negedge clk) begin
        cyc_cnt++;
        if (reset !== 1'b1) begin
            if (m_valid === 1'b1) begin
                outq.push_back({m_data, m_first, m_last, m_fcs_ok, 32'(cyc_cnt)});
            end else if (m_first || m_last || m_fcs_ok || (m_data != 8'd0)) begin
                idle_dirty++;
            end
        end
    end

    // ---------------- frame construction ----------------
    typedef logic [7:0] byte_q_t[$];
    byte_q_t tx;   // whole frame on the wire
    byte_q_t pl;   // payload expected at the output

    // bit-serial reference CRC, returns the FCS value (inverted register)
    function automatic logic [31:0] fcs32(input byte_q_t b);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[i][j];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic build(input int plen, input int flip, input bit bad_pre);
        logic [31:0] fcs;
        tx.delete();
        pl.delete();
        for (int i = 0; i < 7; i++) tx.push_back((bad_pre && i == 3) ? 8'h12 : 8'h55);
        tx.push_back(8'hD5);
        for (int i = 0; i < plen; i++) pl.push_back(8'((i * 37 + 11) ^ (i >> 2)));
        fcs = fcs32(pl);
        if (flip > 0) pl[flip-1] = pl[flip-1] ^ 8'h01;
        foreach (pl[i]) tx.push_back(pl[i]);
        for (int k = 0; k < 4; k++) tx.push_back(fcs[8*k +: 8]);
    endtask

    task automatic idle();
        s_rx_valid = 1'b0;
        s_rx_last  = 1'b0;
        s_rx_data  = 2'd0;
    endtask

    // stop_byte < 0: whole frame with last on the final symbol.
    // otherwise stop on symbol stop_sym of tx[stop_byte], asserting last if with_last.
    task automatic send(input int stop_byte, input int stop_sym, input bit with_last, input bit gap);
        int nb;
        nb = (stop_byte < 0) ? tx.size() : stop_byte + 1;
        for (int bi = 0; bi < nb; bi++) begin
            for (int s = 0; s < 4; s++) begin
                logic [7:0] b;
                bit         at_stop;
                b = tx[bi];
                at_stop = (stop_byte < 0) ? (bi == nb - 1 && s == 3)
                                          : (bi == stop_byte && s == stop_sym);
                @(negedge clk);
                s_rx_valid = 1'b1;
                s_rx_data  = b[2*s +: 2];
                s_rx_last  = at_stop && with_last;
                if (gap) begin
                    @(negedge clk);
                    idle();
                end
                if (at_stop) begin
                    @(negedge clk);
                    idle();
                    return;
                end
            end
        end
    endtask

    // compare the collected output against the expected payload
    task automatic check_frame(input string tag, input int exp_n, input bit exp_ok,
                               input int exp_space, input bit cut_end);
        int data_err, first_err, last_err, space_err;
        data_err = 0; first_err = 0; last_err = 0; space_err = 0;
        check({tag, " count"}, outq.size(), exp_n);
        for (int i = 0; i < outq.size() && i < exp_n; i++) begin
            if (outq[i].d !== pl[i]) data_err++;
            if (outq[i].f !== (i == 0)) first_err++;
            if (outq[i].l !== (i == outq.size() - 1)) last_err++;
            if (i > 0 && !(cut_end && i == outq.size() - 1) &&
                (outq[i].cyc - outq[i-1].cyc) != 32'(exp_space)) space_err++;
        end
        if (exp_n > 0 && outq.size() > 0) begin
            check({tag, " data"},    data_err,  0);
            check({tag, " first"},   first_err, 0);
            check({tag, " last"},    last_err,  0);
            check({tag, " spacing"}, space_err, 0);
            check({tag, " fcs_ok"},  outq[outq.size()-1].ok, exp_ok);
        end
    endtask

    typedef struct {
        string name;
        int    plen;
        int    flip;       // payload byte (1-based) with bit 0 flipped, 0 = none
        bit    bad_pre;
        int    stop_byte;  // -1 = whole frame
        int    stop_sym;
        bit    gap;
        int    exp_n;
        bit    exp_ok;
        int    exp_good;   // cumulative
        int    exp_bad;    // cumulative
        int    exp_space;
    } vec_t;

    vec_t vt[10];

    initial begin
        // tx index 7 is the SFD, data byte k sits at index 7+k
        vt[0] = '{"good60",   60, 0,  0, -1, 0, 0, 60, 1, 1, 0, 4};
        vt[1] = '{"flip10",   60, 10, 0, -1, 0, 0, 60, 0, 1, 1, 4};
        vt[2] = '{"badpre",   60, 0,  1, -1, 0, 0, 0,  0, 1, 1, 4};
        vt[3] = '{"goodafter",60, 0,  0, -1, 0, 0, 60, 1, 2, 1, 4};
        // last on 2nd symbol of the 20th byte counting the SFD as byte 1: 18 full data bytes
        vt[4] = '{"midcut",   60, 0,  0, 26, 1, 0, 15, 0, 2, 2, 4};
        vt[5] = '{"short3",   60, 0,  0, 10, 3, 0, 0,  0, 2, 3, 4};
        vt[6] = '{"gap",      60, 0,  0, -1, 0, 1, 60, 1, 3, 3, 8};
        vt[7] = '{"min5",     1,  0,  0, -1, 0, 0, 1,  1, 4, 3, 4};
        vt[8] = '{"four_mid", 60, 0,  0, 12, 1, 0, 0,  0, 4, 4, 4};
        vt[9] = '{"hunt_end", 60, 0,  0, 3,  3, 0, 0,  0, 4, 4, 4};

        idle();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset m_valid",    m_valid,    0);
        check("reset m_data",     m_data,     0);
        check("reset good_count", good_count, 0);
        check("reset bad_count",  bad_count,  0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            outq.delete();
            build(vt[v].plen, vt[v].flip, vt[v].bad_pre);
            send(vt[v].stop_byte, vt[v].stop_sym, 1'b1, vt[v].gap);
            repeat (12) @(negedge clk);
            check_frame(vt[v].name, vt[v].exp_n, vt[v].exp_ok, vt[v].exp_space, vt[v].stop_byte >= 0);
            check({vt[v].name, " good_count"}, good_count, vt[v].exp_good);
            check({vt[v].name, " bad_count"},  bad_count,  vt[v].exp_bad);
        end

        // reset mid-frame: inside data byte 30, after two of its symbols
        build(60, 0, 0);
        send(37, 1, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check("async rst m_valid",    m_valid,    0);
        check("async rst m_last",     m_last,     0);
        check("async rst good_count", good_count, 0);
        check("async rst bad_count",  bad_count,  0);
        @(negedge clk);
        reset = 1'b0;
        outq.delete();
        repeat (2) @(negedge clk);

        build(60, 0, 0);
        send(-1, 0, 1'b1, 1'b0);
        repeat (12) @(negedge clk);
        check_frame("post_reset", 60, 1'b1, 4, 1'b0);
        check("post_reset good_count", good_count, 1);
        check("post_reset bad_count",  bad_count,  0);

        check("idle outputs zero", idle_dirty, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
